// File: rtl/imem_loader_ctrl.sv
// Instruction-memory loader: owns the imem write port, assembles big-endian words from a
// byte-serial host link and stalls the core during a load. Optional checksum: IMEM_LOADER_CHECKSUM_EN.
module imem_loader_ctrl #(
  parameter int DEPTH = 32,
  parameter int AW    = 5
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic [AW:0]   load_len,
  input  logic          byte_valid,
  input  logic [7:0]    byte_data,
  output logic          byte_ready,
  input  logic [31:0]   pc_out,
  output logic [AW-1:0] mem_addr,
  output logic          mem_we,
  output logic [31:0]   mem_wdata,
  output logic          cpu_stall,
  output logic          pc_clear,
  output logic          busy,
  output logic [AW:0]   words_loaded
`ifdef IMEM_LOADER_CHECKSUM_EN
  ,
  output logic          csum_err
`endif
);

  // Byte handshake: a byte moves on a rising edge where byte_valid and byte_ready are both high.
  // byte_ready is high only while the loader is collecting bytes, so it drops in WRITE/DONE.
`ifdef IMEM_LOADER_CHECKSUM_EN
  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_RECV  = 3'd1,
    S_WRITE = 3'd2,
    S_DONE  = 3'd3,
    S_CSUM  = 3'd4
  } state_t;
`else
  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_RECV  = 3'd1,
    S_WRITE = 3'd2,
    S_DONE  = 3'd3
  } state_t;
`endif

  localparam logic [AW:0] DEPTH_W = (AW + 1)'(DEPTH);
  localparam logic [AW:0] ONE_W   = (AW + 1)'(1);

  state_t        state;
  state_t        state_next;
  logic [AW:0]   len_q;
  logic [1:0]    byte_idx;
  logic [AW-1:0] waddr;
  logic [AW-1:0] waddr_next;
  logic [31:0]   word_q;
  logic          start_ok;
  logic          fire;
  logic          last_word;
  logic          unused_pc;

`ifdef IMEM_LOADER_CHECKSUM_EN
  logic [31:0]   sum_q;
  logic          hold_q;
`endif

  assign unused_pc  = ^{pc_out[31:AW+2], pc_out[1:0]};
  assign start_ok   = start && (load_len != '0) && (load_len <= DEPTH_W);
  assign fire       = byte_valid && byte_ready;
  assign last_word  = (words_loaded + ONE_W) == len_q;
  assign waddr_next = (waddr == AW'(DEPTH - 1)) ? '0 : waddr + AW'(1);
  assign mem_wdata  = word_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    byte_ready = 1'b0;
    mem_we     = 1'b0;
    pc_clear   = 1'b0;
    busy       = (state != S_IDLE);
    mem_addr   = waddr;
`ifdef IMEM_LOADER_CHECKSUM_EN
    cpu_stall  = (state != S_IDLE) || hold_q;
`else
    cpu_stall  = (state != S_IDLE);
`endif
    case (state)
      S_IDLE: begin
        // Fetch path owns the port: zero added latency on instruction reads.
        mem_addr = pc_out[AW+1:2];
        if (start_ok) state_next = S_RECV;
      end
      S_RECV: begin
        byte_ready = 1'b1;
        if (byte_valid && byte_idx == 2'd3) state_next = S_WRITE;
      end
      S_WRITE: begin
        mem_we = 1'b1;
        if (last_word) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
          state_next = S_CSUM;
`else
          state_next = S_DONE;
`endif
        end else begin
          state_next = S_RECV;
        end
      end
`ifdef IMEM_LOADER_CHECKSUM_EN
      S_CSUM: begin
        byte_ready = 1'b1;
        if (byte_valid && byte_idx == 2'd3) state_next = S_DONE;
      end
`endif
      S_DONE: begin
        pc_clear   = 1'b1;
        state_next = S_IDLE;
      end
      default: state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      len_q        <= '0;
      words_loaded <= '0;
      byte_idx     <= '0;
      waddr        <= '0;
      word_q       <= '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
      sum_q        <= '0;
      hold_q       <= 1'b0;
      csum_err     <= 1'b0;
`endif
    end else begin
      // byte_idx wraps 3 -> 0 on the 4th byte, so it is already clear for the next word.
      if (fire) begin
        word_q   <= {word_q[23:0], byte_data};
        byte_idx <= byte_idx + 2'd1;
      end
      case (state)
        S_IDLE: begin
          if (start_ok) begin
            len_q        <= load_len;
            words_loaded <= '0;
            byte_idx     <= '0;
            waddr        <= '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
            sum_q        <= '0;
            hold_q       <= 1'b0;
            csum_err     <= 1'b0;
`endif
          end
        end
        S_WRITE: begin
          waddr        <= waddr_next;
          words_loaded <= words_loaded + ONE_W;
          byte_idx     <= '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
          sum_q        <= sum_q + word_q;
`endif
        end
`ifdef IMEM_LOADER_CHECKSUM_EN
        S_DONE: begin
          // word_q now holds the received checksum.
          csum_err <= (sum_q != word_q);
          hold_q   <= (sum_q != word_q);
        end
`endif
        default: ;
      endcase
    end
  end

endmodule
